brs_result_fifo: RTL and testbench

Buffers the 8-bit results of the conditional XOR/AND bitwise unit. Results arrive on a valid/ready handshake and are queued in a small FIFO. A running XOR checksum and an AND-mode result counter are kept over all accepted words. The block sits directly downstream of the bitwise unit and decouples it from the slower serial readout stage that drains results.

---
 rtl/brs_result_fifo.sv | 105 ++++++++++
 tb/tb_brs_result_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/brs_result_fifo.sv
// Result FIFO behind the conditional XOR/AND bitwise unit. Keeps a running
// XOR checksum and a saturating AND-mode word counter over all accepted words.
module brs_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_mode,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_mode,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         checksum,
    output logic [7:0]               and_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Handshake: a word transfers on an edge where valid && ready; the
    // producer holds its payload while valid && !ready.
    logic [WIDTH:0]    mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  checksum_q, checksum_d;
    logic [7:0]        and_cnt_q, and_cnt_d;
    logic              push;
    logic              pop;
    logic [WIDTH:0]    head;

    // No pass-through when full: in_ready depends only on stored occupancy.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];
    assign out_data  = out_valid ? head[WIDTH-1:0] : '0;
    assign out_mode  = out_valid ? head[WIDTH] : 1'b0;
    assign count     = count_q;
    assign checksum  = checksum_q;
    assign and_cnt   = and_cnt_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        checksum_d = checksum_q;
        and_cnt_d  = and_cnt_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            checksum_d = '0;
            and_cnt_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                checksum_d = checksum_q ^ in_data;
                if (in_mode && (and_cnt_q != 8'hFF)) begin
                    and_cnt_d = and_cnt_q + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            checksum_q <= '0;
            and_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
            and_cnt_q  <= and_cnt_d;
        end
    end

    // Storage is left unreset; entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_q[wr_ptr_q] <= {in_mode, in_data};
        end
    end

endmodule

// File: tb/tb_brs_result_fifo.sv
// Directed bench for brs_result_fifo: scoreboard queue of {mode, data},
// reference checksum/and_cnt, and explicit checks of the listed scenarios.
module tb_brs_result_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic             out_ready;
    logic [2:0]       count;
    logic [WIDTH-1:0] checksum;
    logic [7:0]       and_cnt;

    brs_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_ready (out_ready),
        .count     (count),
        .checksum  (checksum),
        .and_cnt   (and_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH-1:0] mdl_sum;
    logic [7:0]       mdl_and;
    int               n_checks;
    int               n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        mdl_sum = '0;
        mdl_and = '0;
    endtask

    // Compare all outputs against the model at the falling edge, then advance
    // the model by what the coming rising edge should do.
    task automatic step();
        logic [WIDTH:0] head;
        int             occ;
        @(negedge clk);
        occ  = exp_q.size();
        head = (occ != 0) ? exp_q[0] : '0;
        check("in_ready",  in_ready,  occ != DEPTH);
        check("out_valid", out_valid, occ != 0);
        check("count",     count,     occ);
        check("out_data",  out_data,  head[WIDTH-1:0]);
        check("out_mode",  out_mode,  head[WIDTH]);
        check("checksum",  checksum,  mdl_sum);
        check("and_cnt",   and_cnt,   mdl_and);
        if (clr) begin
            model_clear();
        end else begin
            if (out_ready && occ != 0) void'(exp_q.pop_front());
            if (in_valid && occ != DEPTH) begin
                exp_q.push_back({in_mode, in_data});
                mdl_sum = mdl_sum ^ in_data;
                if (in_mode && mdl_and != 8'hFF) mdl_and = mdl_and + 8'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        model_clear();

        // Reset values
        #12;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_mode",  out_mode,  0);
        check("rst_count",     count,     0);
        check("rst_checksum",  checksum,  0);
        check("rst_and_cnt",   and_cnt,   0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single push, one-cycle latency
        in_valid = 1'b1; in_data = 8'h3C; in_mode = 1'b0;
        step();
        in_valid = 1'b0;
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data",  out_data,  8'h3C);
        check("t1_count",     count,     1);
        check("t1_checksum",  checksum,  8'h3C);
        check("t1_and_cnt",   and_cnt,   0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t1_clr_count", count, 0);

        // Fill to full, fifth word held off
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(1 << i); in_mode = 1'b0;
            step();
        end
        in_data = 8'hFF;
        step();
        step();
        in_valid = 1'b0;
        check("t2_count",    count,    4);
        check("t2_in_ready", in_ready, 0);
        check("t2_checksum", checksum, 8'h0F);

        // Drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_order", out_data, 8'(1 << i));
            step();
        end
        check("t3_count",     count,     0);
        check("t3_out_valid", out_valid, 0);
        check("t3_out_data",  out_data,  0);
        check("t3_checksum",  checksum,  8'h0F);
        step();

        // Streaming across pointer wrap, alternating mode
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h10 + i); in_mode = (i % 2 == 0);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("t4_and_cnt",  and_cnt,  5);
        check("t4_checksum", checksum, 8'h01);
        check("t4_count",    count,    0);

        // clr wins over a simultaneous push
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A; in_mode = 1'b1;
        step();
        in_data = 8'h66; in_mode = 1'b0;
        step();
        clr = 1'b1; in_data = 8'hAA; in_mode = 1'b1;
        step();
        clr = 1'b0; in_valid = 1'b0;
        check("t5_count",     count,     0);
        check("t5_checksum",  checksum,  0);
        check("t5_and_cnt",   and_cnt,   0);
        check("t5_out_data",  out_data,  0);
        check("t5_out_valid", out_valid, 0);
        out_ready = 1'b1;
        step();
        step();

        // and_cnt saturation
        in_valid = 1'b1; in_mode = 1'b1;
        for (int i = 0; i < 260; i++) begin
            in_data = 8'($urandom_range(0, 255));
            step();
        end
        in_valid = 1'b0;
        step();
        check("t6_and_sat", and_cnt, 8'hFF);

        // Asynchronous reset mid-stream with two entries stored
        clr = 1'b1;
        step();
        clr = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h81; in_mode = 1'b1;
        step();
        in_data = 8'h42; in_mode = 1'b0;
        step();
        in_valid = 1'b0;
        check("t7_pre_count", count, 2);
        #2;
        rst = 1'b1;
        #1;
        check("t7_count",     count,     0);
        check("t7_out_valid", out_valid, 0);
        check("t7_in_ready",  in_ready,  1);
        check("t7_checksum",  checksum,  0);
        check("t7_and_cnt",   and_cnt,   0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hC3; in_mode = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
